// File: rtl/shift_exec_unit.sv
// shift_exec_unit: registered SRL/SRA/SLL execution stage built around a logical-right barrel shifter.
// Ports: clk, rst (sync, active-high), flush (sync kill of in-flight requests);
//   request  : in_valid, in_ready, in_op (00 SRL, 01 SRA, 10 SLL, 11 illegal), in_data, in_shamt, in_tag
//   result   : out_valid, out_ready, out_data, out_tag, out_err (illegal op)
// Optional macro SHIFT_EXEC_PIPE2_EN: adds stage A between the 1/2/4-bit and 8/16-bit shift levels
//   (latency 2, throughput 1/cycle); undefined gives a single output register (latency 1).
module shift_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam logic [WIDTH-1:0] ONES = '1;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
  endfunction
  // Fine shift levels (1/2/4): the sign-fill mask travels through the same levels as the operand
  logic [WIDTH-1:0] p_lo, p_mlo;
  logic             p_sgn;
  always_comb begin
    p_lo  = (in_op == OP_SLL ? rev(in_data) : in_data) >> in_shamt[2:0];
    p_mlo = ONES >> in_shamt[2:0];
    p_sgn = in_op == OP_SRA && in_data[WIDTH-1];
  end
  logic             b_vld, b_sgn, adv_b;
  logic [WIDTH-1:0] b_lo, b_mlo;
  logic [1:0]       b_op;
  logic [SHW-1:0]   b_hs;
  logic [TAG_W-1:0] b_tag;
  logic             vld_q, err_q;
  logic [WIDTH-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  assign adv_b = !vld_q || out_ready;
`ifdef SHIFT_EXEC_PIPE2_EN
  logic             a_vld_q, a_sgn_q;
  logic [WIDTH-1:0] a_lo_q, a_mlo_q;
  logic [1:0]       a_op_q;
  logic [SHW-1:0]   a_hs_q;
  logic [TAG_W-1:0] a_tag_q;
  assign in_ready = !flush && (!a_vld_q || adv_b);
  always_ff @(posedge clk)
    if (rst || flush) a_vld_q <= 1'b0;
    else if (!a_vld_q || adv_b) begin
      a_vld_q <= in_valid;
      a_lo_q  <= p_lo;
      a_mlo_q <= p_mlo;
      a_op_q  <= in_op;
      a_hs_q  <= in_shamt & ~SHW'(7);
      a_tag_q <= in_tag;
      a_sgn_q <= p_sgn;
    end
  assign b_vld = a_vld_q, b_lo = a_lo_q, b_mlo = a_mlo_q, b_op = a_op_q;
  assign b_hs = a_hs_q, b_tag = a_tag_q, b_sgn = a_sgn_q;
`else
  assign in_ready = !flush && adv_b;
  assign b_vld = in_valid, b_lo = p_lo, b_mlo = p_mlo, b_op = in_op;
  assign b_hs = in_shamt & ~SHW'(7), b_tag = in_tag, b_sgn = p_sgn;
`endif
  // Coarse shift levels (8/16) and post-processing
  logic [WIDTH-1:0] core, data_d;
  always_comb begin
    core   = b_lo >> b_hs;
    data_d = b_op == OP_ILL ? '0 : b_op == OP_SLL ? rev(core) : b_sgn ? core | ~(b_mlo >> b_hs) : core;
  end
  always_ff @(posedge clk)
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else if (flush) vld_q <= 1'b0;
    else if (adv_b) begin
      vld_q <= b_vld;
      if (b_vld) begin
        data_q <= data_d;
        tag_q  <= b_tag;
        err_q  <= b_op == OP_ILL;
      end
    end
  assign out_valid = vld_q, out_data = data_q, out_tag = tag_q, out_err = err_q;
endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: randomized and directed checks of shift_exec_unit against an arithmetic model
module tb_shift_exec_unit;
`ifdef SHIFT_EXEC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
  logic [1:0] in_op = 0;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_shamt = 0, in_tag = 0, out_tag;
  int checks = 0, errors = 0;
  logic [31:0] q_d[$];
  logic [4:0] q_t[$];
  logic q_e[$];
  logic held = 0, hd_e = 0;
  logic [31:0] hd_d = 0;
  logic [4:0] hd_t = 0;
  logic done = 0;
  shift_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00: model = d >> s;
      2'b01: model = sd >>> s;
      2'b10: model = d << s;
      default: model = 32'h0;
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst || flush) begin
      q_d.delete(); q_t.delete(); q_e.delete();
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", out_data, hd_d);
        check("hold_tag", 32'(out_tag), 32'(hd_t));
        check("hold_err", 32'(out_err), 32'(hd_e));
      end
      if (out_valid && out_ready) begin
        if (q_d.size() == 0) check("spurious", 32'(out_valid), 0);
        else begin
          check("sb_data", out_data, q_d.pop_front());
          check("sb_tag", 32'(out_tag), 32'(q_t.pop_front()));
          check("sb_err", 32'(out_err), 32'(q_e.pop_front()));
        end
        held = 0;
      end else if (out_valid) begin
        held = 1; hd_d = out_data; hd_t = out_tag; hd_e = out_err;
      end else held = 0;
      if (in_valid && in_ready) begin
        q_d.push_back(model(in_op, in_data, in_shamt));
        q_t.push_back(in_tag);
        q_e.push_back(in_op == 2'b11);
      end
    end
  end
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s, input logic [4:0] t);
    int n = 0;
    logic acc;
    in_valid = 1; in_op = op; in_data = d; in_shamt = s; in_tag = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 60);
    in_valid = 0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask
  task automatic expect_out(input string tag, input logic [31:0] d, input logic [4:0] t, input logic e);
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_tag"}, 32'(out_tag), 32'(t));
    check({tag, "_err"}, 32'(out_err), 32'(e));
  endtask
  logic [3:0] pat = 4'b1001;
  logic [31:0] r;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_tag", 32'(out_tag), 0);
    check("rst_err", 32'(out_err), 0);
    rst = 0;
    out_ready = 1;
    @(posedge clk); #1;
    send(2'b01, 32'h8000_0000, 5'd31, 5'd3);
    expect_out("sra_ext", 32'hFFFF_FFFF, 5'd3, 1'b0);
    @(posedge clk); #1;
    send(2'b10, 32'h0000_0001, 5'd31, 5'd4);
    expect_out("sll_ext", 32'h8000_0000, 5'd4, 1'b0);
    @(posedge clk); #1;
    send(2'b00, 32'hF000_000F, 5'd4, 5'd5);
    expect_out("srl_4", 32'h0F00_0000, 5'd5, 1'b0);
    for (int op = 0; op < 3; op++) begin
      r = $urandom | 32'h8000_0000;
      @(posedge clk); #1;
      send(2'(op), r, 5'd0, 5'(op));
      expect_out("shamt0", r, 5'(op), 1'b0);
    end
    @(posedge clk); #1;
    send(2'b11, 32'h1234_5678, 5'd9, 5'd7);
    expect_out("illegal", 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), $urandom, 5'($urandom), 5'(i));
        done = 1;
      end
      begin
        int k = 0;
        while (!done) begin out_ready = pat[k % 4]; k++; @(posedge clk); #1; end
      end
    join
    out_ready = 1;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    check("b2b_drain", 32'(q_d.size()), 0);
    @(posedge clk); #1;
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(2'($urandom_range(0, 3)), $urandom, 5'($urandom), 5'($urandom));
        done = 1;
      end
      begin
        while (!done) begin out_ready = 1'($urandom); @(posedge clk); #1; end
      end
    join
    out_ready = 1;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rand_drain", 32'(q_d.size()), 0);
    @(posedge clk); #1;
    out_ready = 0;
    send(2'b00, 32'hDEAD_BEEF, 5'd1, 5'd10);
    in_valid = 1; in_op = 2'b01; in_data = 32'hCAFE_F00D; in_shamt = 5'd2; in_tag = 5'd11;
    @(posedge clk); #1;
    flush = 1; in_tag = 5'd12;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 0);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_stale", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    out_ready = 0;
    send(2'b10, 32'h0000_00FF, 5'd8, 5'd13);
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_tag", 32'(out_tag), 0);
    check("mid_rst_err", 32'(out_err), 0);
    out_ready = 1;
    @(posedge clk); #1;
    send(2'b01, 32'h8000_00F0, 5'd4, 5'd21);
    expect_out("post_rst", 32'hF800_000F, 5'd21, 1'b0);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
